ffmul_result_unpacker: RTL and testbench
========================================

// Module: ffmul_result_unpacker
// PURPOSE
//  Read side of the ffmul datapath: accepts one WIDTH-bit product from the multiplier and returns it to
//  the core as a stream of 32-bit words, least-significant word first. Word count follows the field
//  (ffmul_op_t). Sits between the ffmul core and the EL2 custom writeback path. Bits above the field
//  degree are forced to zero.
// PARAMETERS
//  WIDTH    409  product register width (ffmul_pkg::WIDTH)
//  WORD_W   32   output word width (ffmul_pkg::FF_WORD_W)
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       synchronous reset, active-high
//  flush_i      in   1       synchronous abort; discards any held product
//  res_valid_i  in   1       multiplier presents a product
//  res_ready_o  out  1       unpacker can capture a product
//  res_op_i     in   2       ffmul_op_t of the product (FF409/FF233/FF193/FF113)
//  res_data_i   in   WIDTH   product, bit 0 = x^0 coefficient
//  word_valid_o out  1       output word valid
//  word_ready_i in   1       consumer accepts word
//  word_data_o  out  WORD_W  current output word
//  word_idx_o   out  4       index of current word, 0 = least significant
//  word_last_o  out  1       current word is the final word of this product
//  busy_o       out  1       product held (state SEND)
// BEHAVIOUR
//  - Reset: state IDLE; res_ready_o=1, word_valid_o=0, word_data_o=0, word_idx_o=0, word_last_o=0,
//    busy_o=0; holding register and counter cleared.
//  - States: IDLE, SEND. res_ready_o = (state==IDLE); no combinational path from word_ready_i.
//  - IDLE: res_valid_i & res_ready_o & !flush_i -> capture res_data_i AND ffmask(op) into shift register,
//    load remaining-words = ff_nwords(op) (FF409:13, FF233:8, FF193:7, FF113:4), idx=0, go SEND.
//  - Latency: capture at edge N, first word_valid_o=1 during cycle N+1.
//  - SEND: word_valid_o=1; word_data_o = reg[WORD_W-1:0]; word_last_o = (idx == nwords-1).
//    On word_valid_o & word_ready_i: shift register right by WORD_W, idx++. If last -> IDLE
//    (res_ready_o=1 next cycle; minimum 1 idle cycle between products).
//  - Stall: word_ready_i=0 -> word_data_o, word_idx_o, word_last_o held stable; valid never drops
//    before acceptance.
//  - Masking: ffmask(op) zeroes bits >= degree (409/233/193/113); last word upper bits are zero
//    (FF409 word12 bits[31:25], FF233 word7 [31:9], FF193 word6 [31:1], FF113 word3 [31:17]).
//  - Unused res_op_i encodings: none (all four valid); res_op_i only sampled on capture.
//  - flush_i (any state) -> IDLE next edge, word_valid_o=0, register and idx cleared; flush_i with
//    res_valid_i in IDLE: flush wins, nothing captured (res_ready_o still 1, handshake ignored).
//  - rst mid-SEND: identical to flush; partially sent product lost, no word emitted after reset.
//  - res_valid_i while in SEND: ignored (res_ready_o=0); multiplier must hold it.
//  - Throughput: nwords+1 cycles per product with word_ready_i tied 1.
// STRUCTURE
//  - ffmul_pkg additions: FF_WORD_W=32; N_WORDS_409=13, N_WORDS_233=8, N_WORDS_193=7, N_WORDS_113=4;
//    function ff_nwords(ffmul_op_t) -> logic[3:0]; function ff_degree(ffmul_op_t) -> int;
//    function ffmask(ffmul_op_t) -> logic[WIDTH-1:0]; typedef enum {UNP_IDLE, UNP_SEND} unp_state_t.
//  - Flat module; no sub-module. Shift register is WIDTH bits zero-extended to 13*WORD_W internally.
// TESTING
//  - Reset: assert rst 2 cycles mid-SEND -> next cycle word_valid_o=0, res_ready_o=1, idx=0.
//  - FF113, data = all-ones, word_ready_i=1 -> 4 words 0xFFFFFFFF x3, 0x0001FFFF; last on idx 3;
//    res_ready_o high again 5 cycles after capture.
//  - FF409, data bit k = (k mod 3 == 0) -> 13 words match golden slices, word12 bits[31:25]=0.
//  - FF233 with word_ready_i random 30% -> data/idx/last stable during stalls, 8 words in order.
//  - flush_i on FF193 at idx 3 -> no further valid words; next FF193 product returns all 7 words.
//  - IDLE with res_valid_i and flush_i same cycle -> no capture; busy_o stays 0.

Source files
------------

// File: rtl/ffmul_pkg.sv
// Shared ffmul definitions: field selectors, word geometry and the per-field helper functions.
package ffmul_pkg;

   localparam int unsigned WIDTH        = 409;
   localparam int unsigned FF_WORD_W    = 32;
   localparam int unsigned N_WORDS_409  = 13;
   localparam int unsigned N_WORDS_233  = 8;
   localparam int unsigned N_WORDS_193  = 7;
   localparam int unsigned N_WORDS_113  = 4;
   localparam int unsigned FF_MAX_WORDS = N_WORDS_409;
   localparam int unsigned FF_SHREG_W   = FF_MAX_WORDS * FF_WORD_W;

   typedef enum logic [1:0] {
      FF409 = 2'd0,
      FF233 = 2'd1,
      FF193 = 2'd2,
      FF113 = 2'd3
   } ffmul_op_t;

   typedef enum logic {
      UNP_IDLE = 1'b0,
      UNP_SEND = 1'b1
   } unp_state_t;

   function automatic logic [3:0] ff_nwords(ffmul_op_t op);
      logic [3:0] n;
      case (op)
         FF409:   n = 4'(N_WORDS_409);
         FF233:   n = 4'(N_WORDS_233);
         FF193:   n = 4'(N_WORDS_193);
         default: n = 4'(N_WORDS_113);
      endcase
      return n;
   endfunction

   function automatic int ff_degree(ffmul_op_t op);
      int d;
      case (op)
         FF409:   d = 409;
         FF233:   d = 233;
         FF193:   d = 193;
         default: d = 113;
      endcase
      return d;
   endfunction

   // Ones below the field degree, zeros from the degree upward.
   function automatic logic [WIDTH-1:0] ffmask(ffmul_op_t op);
      return {WIDTH{1'b1}} >> (WIDTH - 32'(ff_degree(op)));
   endfunction

endpackage

// File: rtl/ffmul_result_unpacker.sv
// Returns one ffmul product to the core as 32-bit words, least-significant word first,
// with bits above the field degree forced to zero.
module ffmul_result_unpacker
   import ffmul_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   input  logic                 res_valid_i,
   output logic                 res_ready_o,
   input  logic [1:0]           res_op_i,
   input  logic [WIDTH-1:0]     res_data_i,
   output logic                 word_valid_o,
   input  logic                 word_ready_i,
   output logic [FF_WORD_W-1:0] word_data_o,
   output logic [3:0]           word_idx_o,
   output logic                 word_last_o,
   output logic                 busy_o
);

   unp_state_t            state_q,  state_d;
   logic [FF_SHREG_W-1:0] shreg_q,  shreg_d;
   logic [3:0]            idx_q,    idx_d;
   logic [3:0]            nwords_q, nwords_d;
   logic                  last_q,   last_d;
   ffmul_op_t             op;

   assign op = ffmul_op_t'(res_op_i);

   // Next-state: flush dominates everything; capture only in IDLE, shift only on word acceptance.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      idx_d    = idx_q;
      nwords_d = nwords_q;
      last_d   = last_q;
      if (flush_i) begin
         state_d  = UNP_IDLE;
         shreg_d  = '0;
         idx_d    = '0;
         nwords_d = '0;
         last_d   = 1'b0;
      end else begin
         case (state_q)
            UNP_IDLE: begin
               if (res_valid_i) begin
                  state_d  = UNP_SEND;
                  shreg_d  = FF_SHREG_W'(res_data_i & ffmask(op));
                  idx_d    = '0;
                  nwords_d = ff_nwords(op);
                  last_d   = (ff_nwords(op) == 4'd1);
               end
            end
            default: begin
               if (word_ready_i) begin
                  shreg_d = shreg_q >> FF_WORD_W;
                  if (last_q) begin
                     state_d  = UNP_IDLE;
                     idx_d    = '0;
                     nwords_d = '0;
                     last_d   = 1'b0;
                  end else begin
                     idx_d  = idx_q + 4'd1;
                     last_d = ((idx_q + 4'd2) == nwords_q);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= UNP_IDLE;
         shreg_q  <= '0;
         idx_q    <= '0;
         nwords_q <= '0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         idx_q    <= idx_d;
         nwords_q <= nwords_d;
         last_q   <= last_d;
      end
   end

   // All outputs come straight from flops; the register drains to zero so data reads 0 when idle.
   assign res_ready_o  = (state_q == UNP_IDLE);
   assign word_valid_o = (state_q == UNP_SEND);
   assign busy_o       = (state_q == UNP_SEND);
   assign word_data_o  = shreg_q[FF_WORD_W-1:0];
   assign word_idx_o   = idx_q;
   assign word_last_o  = last_q;

endmodule

// File: tb/tb_ffmul_result_unpacker.sv
// Scoreboard bench for ffmul_result_unpacker: random products against a slice-and-mask reference.
module tb_ffmul_result_unpacker;
   import ffmul_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush_i;
   logic         res_valid_i;
   logic         res_ready_o;
   logic [1:0]   res_op_i;
   logic [408:0] res_data_i;
   logic         word_valid_o;
   logic         word_ready_i;
   logic [31:0]  word_data_o;
   logic [3:0]   word_idx_o;
   logic         word_last_o;
   logic         busy_o;

   ffmul_result_unpacker dut (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush_i),
      .res_valid_i  (res_valid_i),
      .res_ready_o  (res_ready_o),
      .res_op_i     (res_op_i),
      .res_data_i   (res_data_i),
      .word_valid_o (word_valid_o),
      .word_ready_i (word_ready_i),
      .word_data_o  (word_data_o),
      .word_idx_o   (word_idx_o),
      .word_last_o  (word_last_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  idx;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic int degree_of(input logic [1:0] op);
      case (op)
         2'(FF409): return 409;
         2'(FF233): return 233;
         2'(FF193): return 193;
         default:   return 113;
      endcase
   endfunction

   // Reference: clear bits at or above the degree, then cut into 32-bit slices, LSW first.
   task automatic push_expected(input logic [1:0] op, input logic [408:0] data);
      logic [415:0] m;
      int deg, nw;
      deg = degree_of(op);
      nw  = (deg + 31) / 32;
      m   = 416'(data);
      for (int k = deg; k < 416; k++) m[k] = 1'b0;
      for (int i = 0; i < nw; i++) begin
         exp_t e;
         e.data = m[32*i +: 32];
         e.idx  = 4'(i);
         e.last = (i == nw - 1);
         exp_q.push_back(e);
      end
   endtask

   // Monitor: pops on every accepted word and checks stability across stalled cycles.
   logic        have_prev = 1'b0;
   logic [31:0] prev_data;
   logic [3:0]  prev_idx;
   logic        prev_last;

   always @(negedge clk) begin
      if (rst || flush_i) begin
         have_prev = 1'b0;
      end else if (word_valid_o) begin
         if (have_prev) begin
            chk("stall_data", 64'(word_data_o), 64'(prev_data));
            chk("stall_idx",  64'(word_idx_o),  64'(prev_idx));
            chk("stall_last", 64'(word_last_o), 64'(prev_last));
         end
         if (word_ready_i) begin
            have_prev = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(word_idx_o), 64'hDEAD);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("word_data", 64'(word_data_o), 64'(e.data));
               chk("word_idx",  64'(word_idx_o),  64'(e.idx));
               chk("word_last", 64'(word_last_o), 64'(e.last));
            end
         end else begin
            have_prev = 1'b1;
            prev_data = word_data_o;
            prev_idx  = word_idx_o;
            prev_last = word_last_o;
         end
      end else begin
         have_prev = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [408:0] rand_data();
      logic [415:0] t;
      for (int i = 0; i < 13; i++) t[32*i +: 32] = $urandom;
      return t[408:0];
   endfunction

   task automatic capture(input logic [1:0] op, input logic [408:0] data);
      int t;
      t = 0;
      while (!res_ready_o && t < 100) begin step(); t++; end
      if (t >= 100) chk("ready_timeout", 64'(res_ready_o), 64'd1);
      res_valid_i = 1'b1;
      res_op_i    = op;
      res_data_i  = data;
      push_expected(op, data);
      step();
      res_valid_i = 1'b0;
      res_data_i  = rand_data();
      res_op_i    = 2'($urandom_range(0, 3));
      chk("first_valid_latency", 64'(word_valid_o), 64'd1);
      chk("ready_low_in_send", 64'(res_ready_o), 64'd0);
   endtask

   task automatic run_product(input logic [1:0] op, input logic [408:0] data, input int pct);
      int t;
      capture(op, data);
      t = 0;
      while (busy_o && t < 1000) begin
         word_ready_i = ($urandom_range(0, 99) < pct);
         step();
         t++;
      end
      word_ready_i = 1'b0;
      if (t >= 1000) chk("drain_timeout", 64'(busy_o), 64'd0);
      if (pct >= 100) chk("throughput_cycles", 64'(t), 64'((degree_of(op) + 31) / 32));
      chk("ready_after_product", 64'(res_ready_o), 64'd1);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, 64'(word_valid_o), 64'd0);
      chk({tag, "_ready"}, 64'(res_ready_o),  64'd1);
      chk({tag, "_idx"},   64'(word_idx_o),   64'd0);
      chk({tag, "_busy"},  64'(busy_o),       64'd0);
   endtask

   // Abort a product (by flush or reset) while word at_idx is on the bus.
   task automatic run_abort(input logic [1:0] op, input logic [408:0] data, input int at_idx,
                            input logic use_rst);
      int t;
      capture(op, data);
      t = 0;
      while (word_idx_o != 4'(at_idx) && t < 100) begin
         word_ready_i = 1'b1;
         step();
         t++;
      end
      if (t >= 100) chk("abort_idx_timeout", 64'(word_idx_o), 64'(at_idx));
      word_ready_i = 1'b0;
      if (use_rst) begin
         rst = 1'b1;
         step();
         step();
         rst = 1'b0;
      end else begin
         flush_i = 1'b1;
         step();
         flush_i = 1'b0;
      end
      exp_q.delete();
      check_idle(use_rst ? "rst_abort" : "flush_abort");
      word_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("no_word_after_abort", 64'(word_valid_o), 64'd0);
      end
      word_ready_i = 1'b0;
   endtask

   initial begin
      logic [408:0] d;
      rst          = 1'b1;
      flush_i      = 1'b0;
      res_valid_i  = 1'b0;
      res_op_i     = 2'd0;
      res_data_i   = '0;
      word_ready_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_idle("reset");
      chk("reset_data", 64'(word_data_o), 64'd0);
      chk("reset_last", 64'(word_last_o), 64'd0);

      // FF113 all-ones, ready always high
      d = '1;
      run_product(2'(FF113), d, 100);

      // FF409 with every third bit set
      for (int k = 0; k < 409; k++) d[k] = (k % 3 == 0);
      run_product(2'(FF409), d, 100);

      // FF233 with a sparse, random consumer
      run_product(2'(FF233), rand_data(), 30);

      // Flush mid FF193, then a full FF193
      run_abort(2'(FF193), rand_data(), 3, 1'b0);
      run_product(2'(FF193), rand_data(), 100);

      // Reset mid FF409
      run_abort(2'(FF409), rand_data(), 5, 1'b1);

      // Flush and res_valid together in IDLE: no capture
      flush_i     = 1'b1;
      res_valid_i = 1'b1;
      res_op_i    = 2'(FF233);
      res_data_i  = rand_data();
      step();
      flush_i     = 1'b0;
      res_valid_i = 1'b0;
      check_idle("flush_vs_valid");
      step();
      check_idle("flush_vs_valid_later");

      // Random mix
      for (int n = 0; n < 10; n++)
         run_product(2'($urandom_range(0, 3)), rand_data(), ($urandom_range(0, 1) == 1) ? 100 : 30);

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
